i2c_bus_frontend: RTL and testbench

Input conditioning stage in front of `i2c_core`. It synchronises the raw SCL/SDA pins into `I_clk`, rejects glitches shorter than a programmable number of clocks, and emits clean levels plus single-cycle SCL edge, START and STOP strobes. It also tracks bus-busy state and flags a stuck-low SCL. `O_scl`/`O_sda` drive `i2c_core`'s `I_scl`/`I_sda`; the strobes and flags go to the core and to the system status logic.

---
 rtl/i2c_bus_frontend.sv | 127 ++++++++++++
 tb/tb_i2c_bus_frontend.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_frontend.sv
// Input conditioning for the I2C core: pin synchronisers, glitch filters,
// SCL edge / START / STOP strobes, bus-busy tracking and stuck-SCL timeout.
module i2c_bus_frontend #(
  parameter int unsigned FILT_LEN    = 3,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_scl,
  input  logic I_sda,
  output logic O_scl,
  output logic O_sda,
  output logic O_scl_rise,
  output logic O_scl_fall,
  output logic O_start,
  output logic O_stop,
  output logic O_busy,
  output logic O_timeout
);

  // Line index inside the packed per-line vectors.
  localparam int LN_SCL = 1;
  localparam int LN_SDA = 0;

  localparam logic [3:0]  FILT_LAST = 4'(FILT_LEN - 1);
  localparam logic [15:0] TMO_FULL  = 16'(TIMEOUT_CYC);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYC - 1);

  logic [1:0]      meta_q, sync_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0]      prev_q;
  logic [1:0][3:0] fcnt_q, fcnt_d;
  logic [15:0]     tcnt_q, tcnt_d;
  logic            busy_q, busy_d;
  logic            rise_q, fall_q, start_q, stop_q, tmo_q;
  logic            rise_d, fall_d, start_d, stop_d, tmo_d;
  logic            scl_steady_hi;

  // NOTE: synchroniser flops reset to the idle-high bus level so that releasing
  // reset with both pins high produces no transition anywhere downstream.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
    end else begin
      meta_q <= {I_scl, I_sda};
      sync_q <= meta_q;
    end
  end

  // NOTE: every signal written here gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) filt_d[i] = sync_q[i];
        else                        fcnt_d[i] = fcnt_q[i] + 4'd1;
      end
    end
  end

  // Bus conditions are judged on the filtered levels and their one-cycle-old copy.
  always_comb begin
    scl_steady_hi = filt_q[LN_SCL] & prev_q[LN_SCL];
    rise_d  = filt_q[LN_SCL] & ~prev_q[LN_SCL];
    fall_d  = ~filt_q[LN_SCL] & prev_q[LN_SCL];
    start_d = scl_steady_hi & prev_q[LN_SDA] & ~filt_q[LN_SDA];
    stop_d  = scl_steady_hi & ~prev_q[LN_SDA] & filt_q[LN_SDA];

    tcnt_d = tcnt_q;
    tmo_d  = 1'b0;
    if (filt_q[LN_SCL] || start_d) begin
      tcnt_d = '0;
    end else if (tcnt_q == TMO_FULL) begin
      tcnt_d = tcnt_q;  // parked after firing until SCL recovers or a new START
    end else if (busy_q) begin
      tcnt_d = tcnt_q + 16'd1;
      tmo_d  = (tcnt_q == TMO_LAST);
    end else begin
      tcnt_d = '0;
    end

    busy_d = busy_q;
    if (start_d)              busy_d = 1'b1;
    else if (stop_d || tmo_d) busy_d = 1'b0;
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
      busy_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
      busy_q  <= busy_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      tmo_q   <= tmo_d;
    end
  end

  assign O_scl      = filt_q[LN_SCL];
  assign O_sda      = filt_q[LN_SDA];
  assign O_scl_rise = rise_q;
  assign O_scl_fall = fall_q;
  assign O_start    = start_q;
  assign O_stop     = stop_q;
  assign O_busy     = busy_q;
  assign O_timeout  = tmo_q;

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Self-checking bench for i2c_bus_frontend: directed I2C scenarios plus random
// pin activity, compared every cycle against a pin-history reference model.
module tb_i2c_bus_frontend;

  localparam int FL = 3;
  localparam int TC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_pin = 1'b1;
  logic sda_pin = 1'b1;

  logic o_scl, o_sda, o_rise, o_fall, o_start, o_stop, o_busy, o_tmo;
  logic [7:0] outs;
  assign outs = {o_scl, o_sda, o_rise, o_fall, o_start, o_stop, o_busy, o_tmo};

  i2c_bus_frontend #(.FILT_LEN(FL), .TIMEOUT_CYC(TC)) dut (
    .I_clk(clk), .I_rst(rst_n), .I_scl(scl_pin), .I_sda(sda_pin),
    .O_scl(o_scl), .O_sda(o_sda), .O_scl_rise(o_rise), .O_scl_fall(o_fall),
    .O_start(o_start), .O_stop(o_stop), .O_busy(o_busy), .O_timeout(o_tmo)
  );

  always #4 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model. A pin level reaches the filter two edges after it is
  // sampled; the filtered level flips once the last FL filter inputs all
  // disagree with it. Strobes describe what the filtered levels did one edge ago.
  logic [1:0] m_pipe[$];
  logic [1:0] m_win[$];
  logic [1:0] m_f  = 2'b11;
  logic [1:0] m_fp = 2'b11;
  logic       m_busy = 1'b0;
  int         m_low  = 0;
  logic [7:0] exp_o  = 8'b1100_0000;

  always @(posedge clk) begin
    logic [1:0] s, nf;
    logic rise, fall, st, sp, tmo, flip, steady;
    if (!rst_n) begin
      m_pipe = {2'b11, 2'b11};
      m_win.delete();
      m_f = 2'b11; m_fp = 2'b11; m_busy = 1'b0; m_low = 0;
      exp_o = 8'b1100_0000;
    end else begin
      m_pipe.push_back({scl_pin, sda_pin});
      s = m_pipe.pop_front();
      m_win.push_back(s);
      if (m_win.size() > FL) void'(m_win.pop_front());
      nf = m_f;
      for (int l = 0; l < 2; l++) begin
        flip = (m_win.size() == FL);
        foreach (m_win[k]) if (m_win[k][l] == m_f[l]) flip = 1'b0;
        if (flip) nf[l] = ~m_f[l];
      end
      steady = m_f[1] & m_fp[1];
      rise = m_f[1] & ~m_fp[1];
      fall = ~m_f[1] & m_fp[1];
      st   = steady & m_fp[0] & ~m_f[0];
      sp   = steady & ~m_fp[0] & m_f[0];
      if (m_busy && !m_f[1]) m_low++;
      else                   m_low = 0;
      tmo = (m_low == TC);
      if (st)             m_busy = 1'b1;
      else if (sp || tmo) m_busy = 1'b0;
      m_fp = m_f;
      m_f  = nf;
      exp_o = {nf, rise, fall, st, sp, m_busy, tmo};
    end
  end

  // Per-cycle compare plus event bookkeeping for the directed checks.
  int cyc_cnt = 0;
  int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_tmo = 0;
  int n_sda_low = 0, n_busy_fall = 0;
  int last_sda_fall = 0, last_scl_fall = 0, last_tmo = 0;
  logic start_busy = 1'b0;
  logic p_scl = 1'b1, p_sda = 1'b1, p_busy = 1'b0;

  always @(posedge clk) begin
    #1;
    cyc_cnt++;
    check($sformatf("outputs@%0d", cyc_cnt), 32'(outs), 32'(exp_o));
    if (o_rise)  n_rise++;
    if (o_fall)  n_fall++;
    if (o_stop)  n_stop++;
    if (o_start) begin n_start++; start_busy = o_busy; end
    if (o_tmo)   begin n_tmo++; last_tmo = cyc_cnt; end
    if (!o_sda)  n_sda_low++;
    if (p_sda && !o_sda)   last_sda_fall = cyc_cnt;
    if (p_scl && !o_scl)   last_scl_fall = cyc_cnt;
    if (p_busy && !o_busy) n_busy_fall++;
    p_scl = o_scl; p_sda = o_sda; p_busy = o_busy;
  end

  task automatic clear_counts();
    n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0; n_tmo = 0;
    n_sda_low = 0; n_busy_fall = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_pin = 1'b1; scl_pin = 1'b1; cyc(8);
    sda_pin = 1'b0; cyc(6);
    scl_pin = 1'b0; cyc(3);
  endtask

  task automatic i2c_rstart();
    sda_pin = 1'b1; cyc(3);
    scl_pin = 1'b1; cyc(6);
    sda_pin = 1'b0; cyc(6);
    scl_pin = 1'b0; cyc(3);
  endtask

  task automatic i2c_bit(input logic b);
    sda_pin = b; cyc(3);
    scl_pin = 1'b1; cyc(6);
    scl_pin = 1'b0; cyc(3);
  endtask

  task automatic i2c_byte(input logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) i2c_bit(d[i]);
    i2c_bit(ack);
  endtask

  task automatic i2c_stop();
    sda_pin = 1'b0; cyc(3);
    scl_pin = 1'b1; cyc(6);
    sda_pin = 1'b1; cyc(8);
  endtask

  initial begin
    int c0;

    // Reset held with pins toggling, then released with both pins high.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      scl_pin = 1'($urandom_range(0, 1));
      sda_pin = 1'($urandom_range(0, 1));
    end
    check("reset_outputs", 32'(outs), 32'h0000_00C0);
    scl_pin = 1'b1; sda_pin = 1'b1; cyc(2);
    rst_n = 1'b1;
    clear_counts();
    cyc(20);
    check("post_reset_strobes", n_rise + n_fall + n_start + n_stop + n_tmo, 0);

    // Two-clock SDA glitch is swallowed.
    clear_counts();
    sda_pin = 1'b0; cyc(2);
    sda_pin = 1'b1; cyc(12);
    check("glitch2_sda_low", n_sda_low, 0);
    check("glitch2_start", n_start, 0);

    // Three-clock SDA low passes, 5 edges after the first sampling edge.
    clear_counts();
    c0 = cyc_cnt;
    sda_pin = 1'b0; cyc(3);
    sda_pin = 1'b1; cyc(15);
    check("glitch3_latency", last_sda_fall - c0, 5);
    check("glitch3_start", n_start, 1);
    check("glitch3_busy", 32'(start_busy), 1);

    // Full transaction: 0x14 write, reg 0x00, data 0xF0.
    clear_counts();
    i2c_start();
    n_rise = 0;
    i2c_byte(8'h28, 1'b0);
    i2c_byte(8'h00, 1'b0);
    i2c_byte(8'hF0, 1'b0);
    check("xact_rises", n_rise, 27);
    check("xact_busy_mid", 32'(o_busy), 1);
    check("xact_busy_drop", n_busy_fall, 0);
    i2c_stop();
    check("xact_starts", n_start, 1);
    check("xact_stops", n_stop, 1);
    check("xact_busy_end", 32'(o_busy), 0);

    // Repeated START without an intervening STOP.
    clear_counts();
    i2c_start();
    i2c_byte(8'h28, 1'b0);
    i2c_rstart();
    i2c_byte(8'h29, 1'b0);
    check("rstart_starts", n_start, 2);
    check("rstart_busy_drop", n_busy_fall, 0);
    i2c_stop();

    // SCL rises and SDA falls in the same clock.
    scl_pin = 1'b0; cyc(10);
    clear_counts();
    scl_pin = 1'b1; sda_pin = 1'b0; cyc(10);
    check("simul_rise", n_rise, 1);
    check("simul_start", n_start, 0);
    sda_pin = 1'b1; cyc(10);

    // Stuck SCL after START.
    clear_counts();
    i2c_start();
    cyc(40);
    check("stuck_tmo_count", n_tmo, 1);
    check("stuck_tmo_delay", last_tmo - last_scl_fall, TC);
    check("stuck_busy", 32'(o_busy), 0);
    scl_pin = 1'b1; sda_pin = 1'b1; cyc(10);

    // Reset asserted part-way through the stuck count.
    clear_counts();
    i2c_start();
    cyc(8);
    rst_n = 1'b0; cyc(2);
    check("midrst_outputs", 32'(outs), 32'h0000_00C0);
    rst_n = 1'b1; cyc(40);
    check("midrst_tmo", n_tmo, 0);
    check("midrst_busy", 32'(o_busy), 0);
    scl_pin = 1'b1; sda_pin = 1'b1; cyc(10);

    // Random pin activity with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
      end
      scl_pin = 1'($urandom_range(0, 1));
      sda_pin = 1'($urandom_range(0, 1));
      cyc(int'($urandom_range(1, 8)));
    end
    scl_pin = 1'b1; sda_pin = 1'b1; cyc(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
